serial_bit_source: RTL
======================

# serial_bit_source

Parallel-to-serial bit stream source that sits directly upstream of `zero_detector` and drives its `x_in`. It accepts a WIDTH-bit word through a ready/load handshake and emits it one bit per clock on `x_out`, with configurable bit order. Between words it holds a defined idle level. Back-to-back loads produce a gapless stream.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 8: word length in bits; legal range is WIDTH >= 2.
- `LSB_FIRST`, default 0: 0 sends MSB first; 1 sends LSB first.
- `IDLE_BIT`, default 1: level driven on `x_out` when no word is being sent.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  word to serialize; sampled only on an accepted load.
- `load`  in  1  load request; accepted on a rising edge where `load && ready`.
- `ready`  out  1  block can accept a word on this edge.
- `x_out`  out  1  serial bit; connects to `zero_detector.x_in`.
- `bit_valid`  out  1  `x_out` carries a data bit, not idle fill.
- `busy`  out  1  a word is in flight.
- `done`  out  1  one-cycle pulse during the cycle the last bit is on `x_out`.

## Operation
- State:
  - WIDTH-bit shift register `sreg`.
  - Bit counter `cnt`, width $clog2(WIDTH+1).
  - Two-state FSM: IDLE and SHIFT.
- Reset values (asynchronous, while `rst`=0):
  - FSM in IDLE, `sreg`=0, `cnt`=0.
  - `x_out`=IDLE_BIT, `bit_valid`=0, `busy`=0, `done`=0, `ready`=1.
- All outputs are registered or decoded directly from registered state. No combinational path from `load` or `data_in` to any output.
- IDLE:
  - On an accepted load: capture `data_in` into `sreg`, set `cnt`=WIDTH, go to SHIFT.
  - Otherwise: `x_out`=IDLE_BIT, `bit_valid`=0.
- SHIFT:
  - `x_out` = `sreg[WIDTH-1]` if LSB_FIRST=0, else `sreg[0]`.
  - Each edge shifts `sreg` toward the output end and decrements `cnt`.
  - `bit_valid`=1 and `busy`=1 throughout SHIFT.
- Last bit (`cnt`==1):
  - `done`=1 and `ready`=1.
  - On the next edge: a load, if present, reloads `sreg` and sets `cnt`=WIDTH, staying in SHIFT. With no load, go to IDLE.
- `ready` = (IDLE) or (SHIFT and `cnt`==1).
- A load while `ready`=0 is ignored, with no side effects on `sreg`, `cnt` or outputs.
- `data_in` changing while `ready`=0 has no effect.
- Reset asserted mid-word: the word is discarded and all outputs go to reset values immediately (asynchronously). After reset releases, the first edge with `load`=1 is accepted.

## Timing
- Latency: load accepted at edge k → first data bit on `x_out` from edge k through edge k+1 (registered, one cycle).
- Bit i (0-based, in send order) is valid in the cycle following edge k+i. The last bit is in the cycle following edge k+WIDTH-1.
- `done` is high for exactly that last cycle.
- Back-to-back: a load at edge k+WIDTH-1 puts bit 0 of the next word in the cycle immediately after the last bit. There is no idle gap and `bit_valid` stays 1.
- Without a reload, `x_out` returns to IDLE_BIT and `bit_valid` to 0 at edge k+WIDTH.
- Throughput: one word per WIDTH cycles, sustained.

## Test plan
- Basic MSB-first (WIDTH=8, IDLE_BIT=1): load 8'b1011_0010 at edge 1.
  - Required: `x_out` = 1,0,1,1,0,0,1,0 on cycles 2..9, `bit_valid`=1 on cycles 2..9, `done` only on cycle 9.
  - Required: `x_out`=1 and `bit_valid`=0 from cycle 10.
- LSB-first (LSB_FIRST=1): load 8'hB2.
  - Required: `x_out` = 0,1,0,0,1,1,0,1 on cycles 2..9.
- Back-to-back: load 8'hFF, then load 8'h00 on the `done` cycle.
  - Required: eight 1s immediately followed by eight 0s, with `bit_valid` continuously 1 for 16 cycles and `done` pulsing twice.
- Load while busy: load 8'hA5, then assert `load` with 8'h3C on cycles 3..6.
  - Required: the stream is exactly 8'hA5's bits and `ready`=0 on cycles 2..8.
- Reset mid-word: load 8'h0F, then drop `rst` during bit 3.
  - Required: `x_out`=1 and `busy`=0 immediately.
  - Required: a fresh load of 8'h81 after release gives 1,0,0,0,0,0,0,1.
- Chained with `zero_detector`: stream 8'b1101_1000 into its `x_in`.
  - Required: detector output asserts only on zeros that follow a 1.
  - Required: no false detection during IDLE_BIT=1 fill.

Source files
------------

// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_source
// Purpose  : Parallel-to-serial bit source with a ready/load handshake and
//            gapless back-to-back words; feeds zero_detector.x_in.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int         c_CNT_W   = $clog2(WIDTH + 1);
    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_out_bit;
    logic               w_shifting;
    logic               w_last;

    // Bit order only changes which end of sreg is presented and shifted out.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_out_bit = r_sreg[0];
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_out_bit = r_sreg[WIDTH-1];
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    assign w_shifting = (r_state == c_S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == c_CNT_W'(1));

    assign ready     = !w_shifting || w_last;
    assign busy      = w_shifting;
    assign bit_valid = w_shifting;
    assign done      = w_last;
    assign x_out     = w_shifting ? w_out_bit : IDLE_BIT;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (load) begin
                    w_sreg_nxt  = data_in;
                    w_cnt_nxt   = c_CNT_W'(WIDTH);
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                // Reloading on the last bit keeps the stream gapless.
                if (w_last && load) begin
                    w_sreg_nxt = data_in;
                    w_cnt_nxt  = c_CNT_W'(WIDTH);
                end else begin
                    w_sreg_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
